// File: rtl/alu_seq_pkg.sv
// Shared definitions for the two-requester ALU sequencer.
package alu_seq_pkg;

  localparam int unsigned DATA_W = 4;

  // ALU opcodes (sel encoding of alu_4bit)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_INC = 3'b110;
  localparam logic [2:0] OP_DEC = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU. Only ADD and SUB produce a carry; SUB carry = no borrow.
module alu_4bit
  import alu_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  logic [DATA_W:0] sum;

  // Operation decode; logic/INC/DEC leave cout at 0
  always_comb begin
    sum    = '0;
    result = '0;
    cout   = 1'b0;
    unique case (sel)
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_SUB: begin
        sum    = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_INC: result = a + {{(DATA_W-1){1'b0}}, 1'b1};
      OP_DEC: result = a - {{(DATA_W-1){1'b0}}, 1'b1};
    endcase
  end

endmodule

// File: rtl/alu_seq_arb2.sv
// Two-input arbiter producing a one-hot grant; pointer state lives in the parent.
module alu_seq_arb2 #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);

  // Fixed priority favours requester 0; round-robin lets ptr break ties
  always_comb begin
    grant = 2'b00;
    if (PRIO_MODE != 0) begin
      grant = {valid1 & ~valid0, valid0};
    end else if (valid0 && valid1) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = {valid1, valid0};
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Two-requester front end for a shared alu_4bit: arbitrate, latch, execute, respond.
// Optional macro ALU_SEQ_FLAGS_EN adds registered rsp_zero / rsp_neg outputs.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [2:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [2:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_cout,
`ifdef ALU_SEQ_FLAGS_EN
  output logic              rsp_zero,
  output logic              rsp_neg,
`endif
  output logic              busy
);

  state_e            state_q, state_d;
  logic              ptr_q;
  logic              id_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [2:0]        op_q;
  logic [1:0]        grant;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              accept;

  alu_seq_arb2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_arb (
    .valid0(req0_valid),
    .valid1(req1_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  alu_4bit u_alu (
    .a     (a_q),
    .b     (b_q),
    .sel   (op_q),
    .result(alu_result),
    .cout  (alu_cout)
  );

  // Next state and handshake outputs; grants only reach requesters in IDLE
  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    unique case (state_q)
      StIdle: begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        accept     = |grant;
        if (accept) state_d = StExec;
      end
      StExec: state_d = StResp;
      StResp: if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_id    = id_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Operand latch on accept, result capture in EXEC, pointer advance on response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= 1'b0;
      ptr_q      <= 1'b0;
      rsp_result <= '0;
      rsp_cout   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      rsp_zero   <= 1'b0;
      rsp_neg    <= 1'b0;
`endif
    end else begin
      if (accept) begin
        a_q  <= grant[1] ? req1_a  : req0_a;
        b_q  <= grant[1] ? req1_b  : req0_b;
        op_q <= grant[1] ? req1_op : req0_op;
        id_q <= grant[1];
      end
      if (state_q == StExec) begin
        rsp_result <= alu_result;
        rsp_cout   <= alu_cout;
`ifdef ALU_SEQ_FLAGS_EN
        rsp_zero   <= (alu_result == '0);
        rsp_neg    <= alu_result[DATA_W-1];
`endif
      end
      // Pointer moves to the requester that did not just win
      if ((state_q == StResp) && rsp_ready) ptr_q <= ~id_q;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: u0 is round-robin, u1 is fixed-priority, both see the same stimulus.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;

  logic       r0_ready, r1_ready, rvalid, rid, rcout, rbusy;
  logic [3:0] rres;
  logic       p0_ready, p1_ready, pvalid, pid, pcout, pbusy;
  logic [3:0] pres;
`ifdef ALU_SEQ_FLAGS_EN
  logic       rzero, rneg, pzero, pneg;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.PRIO_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(r0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(rvalid), .rsp_ready(rsp_ready), .rsp_id(rid), .rsp_result(rres),
    .rsp_cout(rcout),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(rzero), .rsp_neg(rneg),
`endif
    .busy(rbusy)
  );

  alu_op_sequencer #(.PRIO_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(p0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(p1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op),
    .rsp_valid(pvalid), .rsp_ready(rsp_ready), .rsp_id(pid), .rsp_result(pres),
    .rsp_cout(pcout),
`ifdef ALU_SEQ_FLAGS_EN
    .rsp_zero(pzero), .rsp_neg(pneg),
`endif
    .busy(pbusy)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " req0_ready"}, {7'd0, r0_ready}, 8'd0);
    check({tag, " req1_ready"}, {7'd0, r1_ready}, 8'd0);
    check({tag, " rsp_valid"},  {7'd0, rvalid},   8'd0);
    check({tag, " rsp_id"},     {7'd0, rid},      8'd0);
    check({tag, " rsp_cout"},   {7'd0, rcout},    8'd0);
    check({tag, " rsp_result"}, {4'd0, rres},     8'd0);
    check({tag, " busy"},       {7'd0, rbusy},    8'd0);
  endtask

  // Issue one command on u0, check accept, EXEC and the response; handshake
  // completes at the edge after the task returns (rsp_ready held high).
  task automatic run_cmd(input string tag, input bit id, input logic [3:0] a,
                         input logic [3:0] b, input logic [2:0] op,
                         input logic [3:0] exp_res, input logic exp_cout);
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    check({tag, " ready"}, {7'd0, (id ? r1_ready : r0_ready)}, 8'd1);
    check({tag, " other_ready"}, {7'd0, (id ? r0_ready : r1_ready)}, 8'd0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check({tag, " exec_busy"},  {7'd0, rbusy},  8'd1);
    check({tag, " exec_valid"}, {7'd0, rvalid}, 8'd0);
    @(negedge clk);
    #1;
    check({tag, " rsp_valid"},  {7'd0, rvalid}, 8'd1);
    check({tag, " rsp_result"}, {4'd0, rres},   {4'd0, exp_res});
    check({tag, " rsp_cout"},   {7'd0, rcout},  {7'd0, exp_cout});
    check({tag, " rsp_id"},     {7'd0, rid},    {7'd0, id});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Basic arithmetic
    run_cmd("add_7_9",  1'b0, 4'h7, 4'h9, 3'b000, 4'h0, 1'b1);
    run_cmd("sub_5_3",  1'b1, 4'h5, 4'h3, 3'b001, 4'h2, 1'b1);
    run_cmd("sub_3_5",  1'b1, 4'h3, 4'h5, 3'b001, 4'hE, 1'b0);
    run_cmd("dec_0",    1'b0, 4'h0, 4'h0, 3'b111, 4'hF, 1'b0);
    run_cmd("or_9_6",   1'b0, 4'h9, 4'h6, 3'b011, 4'hF, 1'b0);

    // Contention: both valid continuously from a fresh reset
    do_reset();
    req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_op = 3'b000;
    req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2; req1_op = 3'b000;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_grant0_%0d", k), {7'd0, r0_ready}, {7'd0, (k % 2 == 0)});
      check($sformatf("rr_grant1_%0d", k), {7'd0, r1_ready}, {7'd0, (k % 2 == 1)});
      check($sformatf("fp_grant0_%0d", k), {7'd0, p0_ready}, 8'd1);
      check($sformatf("fp_grant1_%0d", k), {7'd0, p1_ready}, 8'd0);
      repeat (2) @(negedge clk);
      #1;
      check($sformatf("rr_id_%0d", k),  {7'd0, rid},  {7'd0, (k % 2 == 1)});
      check($sformatf("rr_res_%0d", k), {4'd0, rres}, (k % 2 == 1) ? 8'd4 : 8'd2);
      check($sformatf("fp_id_%0d", k),  {7'd0, pid},  8'd0);
      check($sformatf("fp_valid_%0d", k), {7'd0, pvalid}, 8'd1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Backpressure: AND C&A = 8 held in RESP while req1 waits
    do_reset();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hA; req0_op = 3'b010;
    #1;
    check("bp_accept", {7'd0, r0_ready}, 8'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h2; req1_op = 3'b000;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("bp_valid_%0d", k),  {7'd0, rvalid},   8'd1);
      check($sformatf("bp_result_%0d", k), {4'd0, rres},     8'h8);
      check($sformatf("bp_cout_%0d", k),   {7'd0, rcout},    8'd0);
      check($sformatf("bp_id_%0d", k),     {7'd0, rid},      8'd0);
      check($sformatf("bp_r0_%0d", k),     {7'd0, r0_ready}, 8'd0);
      check($sformatf("bp_r1_%0d", k),     {7'd0, r1_ready}, 8'd0);
      check($sformatf("bp_busy_%0d", k),   {7'd0, rbusy},    8'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_valid", {7'd0, rvalid},   8'd0);
    check("bp_release_busy",  {7'd0, rbusy},    8'd0);
    check("bp_waiter_ready",  {7'd0, r1_ready}, 8'd1);
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    #1;
    check("bp_waiter_valid",  {7'd0, rvalid}, 8'd1);
    check("bp_waiter_result", {4'd0, rres},   8'h3);
    check("bp_waiter_id",     {7'd0, rid},    8'd1);

    // Reset during EXEC of INC F discards the command
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'hF; req0_b = 4'h0; req0_op = 3'b110;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check("rst_exec_busy", {7'd0, rbusy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_exec");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("rst_no_rsp_%0d", k), {7'd0, rvalid}, 8'd0);
    end
    run_cmd("inc_F", 1'b0, 4'hF, 4'h0, 3'b110, 4'h0, 1'b0);

`ifdef ALU_SEQ_FLAGS_EN
    run_cmd("xor_A_A", 1'b0, 4'hA, 4'hA, 3'b100, 4'h0, 1'b0);
    check("xor_zero", {7'd0, rzero}, 8'd1);
    check("xor_neg",  {7'd0, rneg},  8'd0);
    run_cmd("not_1", 1'b1, 4'h1, 4'h0, 3'b101, 4'hE, 1'b0);
    check("not_zero", {7'd0, rzero}, 8'd0);
    check("not_neg",  {7'd0, rneg},  8'd1);
`endif

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Two-requester front end for the shared 4-bit ALU datapath (`alu_4bit`). It arbitrates between two independent command streams and latches the winner's operands and opcode. It drives the single ALU instance and returns the registered result, carry and requester ID over a valid/ready response channel. It sits between the two ALU clients and the ALU, so neither client needs its own ALU copy.

## Interface
- `PRIO_MODE`, default 0: 0 selects round-robin arbitration; 1 gives requester 0 fixed priority.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: requester 0 has a command.
- `req0_ready` out 1: requester 0's command is accepted this cycle.
- `req0_a`, `req0_b` in 4 each: requester 0 operands.
- `req0_op` in 3: requester 0 opcode, using the ALU `sel` encoding.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `rsp_valid` out 1: a response is available.
- `rsp_ready` in 1: the consumer takes the response.
- `rsp_id` out 1: the requester that owns the response.
- `rsp_result` out 4: ALU result.
- `rsp_cout` out 1: ALU carry out.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, EXEC and RESP. After reset the FSM is in IDLE with the priority pointer set to requester 0.
- **IDLE**
  - If any `reqN_valid` is high, the arbiter picks one winner.
  - `reqN_ready` is asserted combinationally for the winner only. The handshake completes in that same cycle.
  - On the handshake, `a`, `b` and `op` are latched into operand registers, the winner ID is latched, and the FSM moves to EXEC.
  - With no request, the FSM stays in IDLE.
- **EXEC**
  - The latched operands drive the ALU.
  - At the clock edge, the ALU `result` and `cout` are captured into `rsp_result` and `rsp_cout`, and the FSM moves to RESP.
- **RESP**
  - `rsp_valid` is high. `rsp_result`, `rsp_cout` and `rsp_id` stay stable until `rsp_valid && rsp_ready`.
  - On that handshake, the FSM returns to IDLE and the pointer is updated.
- **Arbitration, round-robin (`PRIO_MODE` = 0)**
  - When both requesters are valid, the requester named by the pointer wins.
  - After a completed response, the pointer moves to the other requester (not the winner).
  - If only one requester is valid, it wins regardless of the pointer.
- **Arbitration, fixed priority (`PRIO_MODE` = 1)**: requester 0 always wins when valid. The pointer is unused.
- `reqN_ready` is 0 in EXEC and RESP. No new command is accepted while a result is outstanding.
- Arithmetic is the ALU's own:
  - ADD/SUB are 4-bit with carry out. SUB is computed as `a + ~b + 1`, so `cout` = 1 means no borrow.
  - Logic, INC and DEC produce `cout` = 0.
  - All results wrap modulo 16.
- **Reset asserted mid-operation** (EXEC or RESP): the in-flight command is discarded with no response. Requesters must resubmit after reset.
- **Reset values**
  - `req0_ready`, `req1_ready`, `rsp_valid`, `rsp_id`, `rsp_cout`, `busy` = 0.
  - `rsp_result` = 4'h0.
  - Operand registers = 0. State = IDLE. Pointer = 0.

## Timing
- Handshake accepted at the cycle-N edge → EXEC in cycle N+1 → `rsp_valid` high in cycle N+2.
- Minimum issue interval is 3 cycles per command, with `rsp_ready` held high.
- Backpressure: while `rsp_ready` is low, RESP holds indefinitely with all response outputs frozen.
- A request that appears while `busy` is high waits. Its `reqN_valid` must stay high until `reqN_ready` is seen.
- `rsp_ready` is ignored outside RESP.

## Configuration
- Macro: `ALU_SEQ_FLAGS_EN`.
- **Defined**:
  - Adds output ports `rsp_zero` (1 bit, high when the result is 4'h0) and `rsp_neg` (1 bit, equal to result bit 3).
  - Both are registered in EXEC together with `rsp_result`, reset to 0, and held stable in RESP.
- **Undefined**: these ports and their flag registers do not exist. All other behaviour is identical.

## Structure
- `alu_seq_pkg` holds:
  - opcode constants: `OP_ADD`=000, `OP_SUB`=001, `OP_AND`=010, `OP_OR`=011, `OP_XOR`=100, `OP_NOT`=101, `OP_INC`=110, `OP_DEC`=111;
  - the state enum (IDLE, EXEC, RESP);
  - `DATA_W` = 4.
- Sub-module `alu_seq_arb2`: two-input arbiter. Inputs are the two valids, the pointer and `PRIO_MODE`; output is a one-hot grant. The pointer register stays in the parent.
- The parent instantiates `alu_4bit` once.

## Test plan
- ADD: req0 with a=7, b=9, op=000 → `rsp_valid` 2 cycles after accept, with `rsp_result`=0, `rsp_cout`=1, `rsp_id`=0.
- SUB: req1 with a=5, b=3, op=001 → `rsp_result`=2, `rsp_cout`=1, `rsp_id`=1. Then a=3, b=5 → `rsp_result`=4'hE, `rsp_cout`=0.
- Contention: both requesters valid every cycle after reset, round-robin, `rsp_ready` high → grants alternate 0,1,0,1. With `PRIO_MODE`=1, the same stimulus → all grants go to 0.
- Backpressure: `rsp_ready` low for 5 cycles in RESP → outputs stable, both `reqN_ready` stay 0, `busy`=1. Release → exactly one response, then back to IDLE.
- Reset in EXEC: assert `rst_n` low during EXEC of INC a=4'hF → all outputs return to reset values and no `rsp_valid` appears. After release, a resubmitted INC a=4'hF → `rsp_result`=0, `rsp_cout`=0.
- Flags, with `ALU_SEQ_FLAGS_EN` defined: XOR a=4'hA, b=4'hA → `rsp_zero`=1, `rsp_neg`=0. NOT a=4'h1 → `rsp_result`=4'hE, `rsp_neg`=1, `rsp_zero`=0.
